prom_rr_controller: RTL and testbench

- Round-robin read controller that shares one 16-word x 4-bit registered PROM (one-cycle read latency, read only while enable=1, output undefined when disabled) between two requesters.
- Each requester asks for a burst of 1–16 consecutive words from a start address. The controller sequences the PROM address and enable lines, returns the data tagged per requester, and signals burst completion.
- Sits between the PROM instance and its client blocks. The PROM is never driven by anyone else.

---
 rtl/prom_rr_controller.sv | 165 ++++++++++++++++
 tb/tb_prom_rr_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prom_rr_controller.sv
// Round-robin read controller sharing one registered PROM between two burst requesters.
// Issues consecutive PROM addresses, captures the returned words and tags them per requester.
module prom_rr_controller #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] len0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] len1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              done0,
    output logic              done1,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_enable,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    // Burst bookkeeping: owner of the active burst, issues still to go after the current one
    logic              last_served;
    logic              last_served_n;
    logic              owner;
    logic              owner_n;
    logic [ADDR_W-1:0] remain;
    logic [ADDR_W-1:0] remain_n;
    logic              pick;

    // Capture stage: describes the word the PROM presents on rom_data this cycle
    logic cap_en;
    logic cap_en_n;
    logic cap_last;
    logic cap_last_n;
    logic cap_owner;
    logic cap_owner_n;

    logic              gnt0_n;
    logic              gnt1_n;
    logic              rvalid0_n;
    logic              rvalid1_n;
    logic [DATA_W-1:0] rdata_n;
    logic              done0_n;
    logic              done1_n;
    logic              busy_n;
    logic [ADDR_W-1:0] rom_address_n;
    logic              rom_enable_n;

    // Next-state, arbitration and next-output logic
    always_comb begin
        state_n       = state;
        last_served_n = last_served;
        owner_n       = owner;
        remain_n      = remain;
        pick          = 1'b0;
        gnt0_n        = 1'b0;
        gnt1_n        = 1'b0;
        rom_enable_n  = 1'b0;
        rom_address_n = rom_address;

        cap_en_n    = rom_enable;
        cap_last_n  = rom_enable && (remain == '0);
        cap_owner_n = owner;

        rvalid0_n = cap_en && !cap_owner;
        rvalid1_n = cap_en && cap_owner;
        done0_n   = rvalid0_n && cap_last;
        done1_n   = rvalid1_n && cap_last;
        rdata_n   = cap_en ? rom_data : rdata;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    pick          = (req0 && req1) ? !last_served : req1;
                    owner_n       = pick;
                    last_served_n = pick;
                    gnt0_n        = !pick;
                    gnt1_n        = pick;
                    rom_enable_n  = 1'b1;
                    rom_address_n = pick ? addr1 : addr0;
                    remain_n      = pick ? len1 : len0;
                    state_n       = ISSUE;
                end
            end
            ISSUE: begin
                if (remain == '0) begin
                    state_n = DRAIN;
                end else begin
                    rom_enable_n  = 1'b1;
                    rom_address_n = rom_address + ADDR_W'(1);
                    remain_n      = remain - ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Last word leaves the capture stage together with done
                if (done0 || done1) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= 1'b1;
            owner       <= 1'b0;
            remain      <= '0;
            cap_en      <= 1'b0;
            cap_last    <= 1'b0;
            cap_owner   <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rdata       <= '0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            busy        <= 1'b0;
            rom_address <= '0;
            rom_enable  <= 1'b0;
        end else begin
            state       <= state_n;
            last_served <= last_served_n;
            owner       <= owner_n;
            remain      <= remain_n;
            cap_en      <= cap_en_n;
            cap_last    <= cap_last_n;
            cap_owner   <= cap_owner_n;
            gnt0        <= gnt0_n;
            gnt1        <= gnt1_n;
            rvalid0     <= rvalid0_n;
            rvalid1     <= rvalid1_n;
            rdata       <= rdata_n;
            done0       <= done0_n;
            done1       <= done1_n;
            busy        <= busy_n;
            rom_address <= rom_address_n;
            rom_enable  <= rom_enable_n;
        end
    end

endmodule

// File: tb/tb_prom_rr_controller.sv
// Directed bench for prom_rr_controller with a registered 16x4 PROM model.
module tb_prom_rr_controller;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req0  = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic [ADDR_W-1:0] len0  = '0;
    logic              req1  = 1'b0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic [ADDR_W-1:0] len1  = '0;
    logic              gnt0, gnt1, rvalid0, rvalid1, done0, done1, busy, rom_enable;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        bit         who;
        logic [3:0] addr;
        logic [3:0] len;
        int         drop;
        logic [3:0] first_word;
        logic [3:0] last_word;
    } vec_t;

    vec_t vecs[6];

    int gc[$];
    int gw[$];
    int w0[$];
    int w1[$];
    int overlap;
    int activity;
    int exp_w0[4];
    int exp_w1[4];

    prom_rr_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .addr0(addr0), .len0(len0),
        .req1(req1), .addr1(addr1), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .done0(done0), .done1(done1), .busy(busy),
        .rom_address(rom_address), .rom_enable(rom_enable), .rom_data(rom_data)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] rom_val(input logic [3:0] a);
        case (a)
            4'd0:  return 4'd2;
            4'd1:  return 4'd4;
            4'd2:  return 4'd6;
            4'd3:  return 4'd8;
            4'd4:  return 4'd10;
            4'd5:  return 4'd12;
            4'd6:  return 4'd14;
            4'd7:  return 4'd0;
            4'd8:  return 4'd1;
            4'd9:  return 4'd3;
            4'd10: return 4'd5;
            4'd11: return 4'd7;
            4'd12: return 4'd9;
            4'd13: return 4'd11;
            4'd14: return 4'd13;
            default: return 4'd15;
        endcase
    endfunction

    // Disabled PROM returns scrambled data so stray captures are visible
    always_ff @(posedge clock) begin
        rom_data <= rom_enable ? rom_val(rom_address) : (rom_val(rom_address) ^ 4'h5);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs_all();
        return int'({gnt0, gnt1, rvalid0, rvalid1, done0, done1, busy, rom_enable,
                     rom_address, rdata});
    endfunction

    function automatic int ctl();
        return int'({gnt0, gnt1, busy, rom_enable, rvalid0, rvalid1, done0, done1});
    endfunction

    task automatic reset_dut();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drive_req(input bit who, input bit val, input logic [3:0] a, input logic [3:0] l);
        if (!who) begin
            req0 = val; addr0 = a; len0 = l;
        end else begin
            req1 = val; addr1 = a; len1 = l;
        end
    endtask

    // One burst from an idle controller; cycle 0 is the negedge cycle where req is raised
    task automatic run_burst(input vec_t v);
        int n;
        int drop;
        int en_cnt;
        int nw;
        logic [3:0] fw;
        logic [3:0] lw;
        logic g, b, e, rv, d;
        logic [7:0] exp_ctl;
        n      = int'(v.len) + 1;
        drop   = (v.drop == 0) ? n + 2 : v.drop;
        en_cnt = 0;
        nw     = 0;
        fw     = '0;
        lw     = '0;
        drive_req(v.who, 1'b1, v.addr, v.len);
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clock);
            g  = (c == 1);
            b  = (c <= n + 2);
            e  = (c <= n);
            rv = (c >= 3) && (c <= n + 2);
            d  = (c == n + 2);
            exp_ctl = {g & ~v.who, g & v.who, b, e, rv & ~v.who, rv & v.who, d & ~v.who, d & v.who};
            check($sformatf("%s.ctl.c%0d", v.name, c), ctl(), int'(exp_ctl));
            if (rom_enable) en_cnt++;
            if (e) check($sformatf("%s.addr.c%0d", v.name, c), int'(rom_address),
                         int'(4'(v.addr + 4'(c - 1))));
            if (rv) begin
                check($sformatf("%s.rdata.c%0d", v.name, c), int'(rdata),
                      int'(rom_val(4'(v.addr + 4'(c - 3)))));
                if (nw == 0) fw = rdata;
                lw = rdata;
                nw++;
            end
            if (c == n + 3) check($sformatf("%s.hold", v.name), int'(rdata), int'(v.last_word));
            if (c == drop) drive_req(v.who, 1'b0, v.addr, v.len);
        end
        check($sformatf("%s.en_cycles", v.name), en_cnt, n);
        check($sformatf("%s.words", v.name), nw, n);
        check($sformatf("%s.first", v.name), int'(fw), int'(v.first_word));
        check($sformatf("%s.last", v.name), int'(lw), int'(v.last_word));
        repeat (2) begin
            @(negedge clock);
            check($sformatf("%s.idle", v.name), ctl(), 0);
        end
    endtask

    initial begin
        vecs[0] = '{name:"single",  who:1'b0, addr:4'd2,  len:4'd0,  drop:0, first_word:4'd6,  last_word:4'd6};
        vecs[1] = '{name:"wrap",    who:1'b0, addr:4'd14, len:4'd2,  drop:0, first_word:4'd13, last_word:4'd2};
        vecs[2] = '{name:"full",    who:1'b1, addr:4'd0,  len:4'd15, drop:0, first_word:4'd2,  last_word:4'd15};
        vecs[3] = '{name:"r1mid",   who:1'b1, addr:4'd5,  len:4'd3,  drop:0, first_word:4'd12, last_word:4'd1};
        vecs[4] = '{name:"r0top",   who:1'b0, addr:4'd15, len:4'd0,  drop:0, first_word:4'd15, last_word:4'd15};
        vecs[5] = '{name:"dropreq", who:1'b0, addr:4'd4,  len:4'd3,  drop:1, first_word:4'd10, last_word:4'd0};
        exp_w0 = '{2, 4, 2, 4};
        exp_w1 = '{1, 3, 1, 3};

        reset_dut();
        check("reset.outs", outs_all(), 0);

        for (int i = 0; i < 6; i++) run_burst(vecs[i]);

        // Both requesters held high: strict alternation starting with requester 0
        reset_dut();
        req0 = 1'b1; addr0 = 4'd0; len0 = 4'd1;
        req1 = 1'b1; addr1 = 4'd8; len1 = 4'd1;
        overlap = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (gnt0 || gnt1) begin
                gc.push_back(c);
                gw.push_back(int'(gnt1));
            end
            if (rvalid0) w0.push_back(int'(rdata));
            if (rvalid1) w1.push_back(int'(rdata));
            if (rvalid0 && rvalid1) overlap++;
            if (c == 20) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        check("rr.grants", gc.size(), 4);
        for (int k = 0; k < gc.size() && k < 4; k++) begin
            check($sformatf("rr.gnt_cycle%0d", k), gc[k], 1 + 5 * k);
            check($sformatf("rr.gnt_who%0d", k), gw[k], k % 2);
        end
        check("rr.w0_count", w0.size(), 4);
        check("rr.w1_count", w1.size(), 4);
        for (int k = 0; k < w0.size() && k < 4; k++) check($sformatf("rr.w0_%0d", k), w0[k], exp_w0[k]);
        for (int k = 0; k < w1.size() && k < 4; k++) check($sformatf("rr.w1_%0d", k), w1[k], exp_w1[k]);
        check("rr.overlap", overlap, 0);
        repeat (2) @(negedge clock);
        check("rr.idle", ctl(), 0);

        // Reset in the middle of a burst, then arbitration restarts from requester 0
        reset_dut();
        req0 = 1'b1; addr0 = 4'd0; len0 = 4'd7;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            if (c == 1) check("rst.gnt", int'({gnt0, gnt1}), 2);
            if (c == 3) check("rst.word1", int'({rvalid0, rdata}), int'({1'b1, 4'd2}));
        end
        reset = 1'b1;
        req0  = 1'b0;
        @(negedge clock);
        check("rst.outs", outs_all(), 0);
        reset = 1'b0;
        activity = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            activity += ctl();
        end
        check("rst.quiet", activity, 0);
        req0 = 1'b1; addr0 = 4'd3; len0 = 4'd0;
        req1 = 1'b1; addr1 = 4'd9; len1 = 4'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (c == 1) check("rst.first_gnt", int'({gnt0, gnt1}), 2);
            if (c == 3) begin
                check("rst.done0", int'({rvalid0, done0, rdata}), int'({2'b11, 4'd8}));
                req0 = 1'b0;
            end
            if (c == 5) begin
                check("rst.second_gnt", int'({gnt0, gnt1}), 1);
                req1 = 1'b0;
            end
            if (c == 7) check("rst.done1", int'({rvalid1, done1, rdata}), int'({2'b11, 4'd3}));
            if (c == 8) check("rst.end_idle", ctl(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
